// File: rtl/cpu_defs.sv
// cpu_defs: definitions shared by the front-end blocks.
//   if_state_e  - instruction fetch FSM encodings (IF_RUN / IF_HALT)
//   IMEM_WORDS  - instruction memory depth in 32-bit words
//   RESET_PC    - default program counter after reset
//   NOP         - all-zero instruction word used as the cleared output value
package cpu_defs;

    typedef enum logic {
        IF_RUN  = 1'b0,
        IF_HALT = 1'b1
    } if_state_e;

    localparam int          IMEM_WORDS = 1024;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0000;

endpackage

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit.
//   Owns the PC, presents it to a combinational instruction ROM and registers
//   the returned word (with its PC) into a one-entry valid/ready output stage.
//   Redirects from later stages flush that stage; an illegal fetch or redirect
//   address halts the unit with a sticky fault until reset.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   imem_addr   out   - byte address to the ROM (the PC register itself)
//   imem_instr  in    - ROM word for imem_addr
//   redirect_valid/redirect_pc in - PC change request
//   out_valid/out_ready/out_instr/out_pc - output stage toward decode
//   fault       out   - sticky illegal-address indication
module ifetch
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
    parameter int          IMEM_WORDS = cpu_defs::IMEM_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    // 33-bit compare so a large IMEM_WORDS cannot wrap the limit.
    localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) << 2;

    if_state_e   state, state_n;
    logic [31:0] pc, pc_n;
    logic        valid_n;
    logic [31:0] instr_n, opc_n;
    logic        fault_n;

    logic slot_free;
    logic redirect_bad;
    logic pc_bad;

    assign slot_free    = !out_valid || out_ready;
    assign redirect_bad = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= LIMIT);
    // Checked before every fetch, so PC running off the ROM end halts before
    // the +4 arithmetic could ever wrap back to low addresses.
    assign pc_bad       = {1'b0, pc} >= LIMIT;

    assign imem_addr = pc;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = out_valid;
        instr_n = out_instr;
        opc_n   = out_pc;
        fault_n = fault;
        case (state)
            IF_RUN: begin
                if (redirect_valid && redirect_bad) begin
                    fault_n = 1'b1;
                    state_n = IF_HALT;
                    valid_n = 1'b0;
                end else if (redirect_valid) begin
                    // Flush: whatever sits in the output stage is wrong-path.
                    pc_n    = redirect_pc;
                    valid_n = 1'b0;
                end else if (pc_bad && slot_free) begin
                    fault_n = 1'b1;
                    state_n = IF_HALT;
                    valid_n = 1'b0;
                end else if (slot_free) begin
                    instr_n = imem_instr;
                    opc_n   = pc;
                    valid_n = 1'b1;
                    pc_n    = pc + 32'd4;
                end
            end
            default: begin
                // HALT: everything holds; out_valid was cleared on entry.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IF_RUN;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= NOP;
            out_pc    <= 32'h0;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            out_valid <= valid_n;
            out_instr <= instr_n;
            out_pc    <= opc_n;
            fault     <= fault_n;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

    localparam int WORDS = 1024;
    localparam logic [31:0] LIM = 32'(WORDS * 4);

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    logic [31:0] rom [0:WORDS-1];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural view only (next PC, held output, halted flag).
    logic [31:0] m_pc, m_instr, m_opc;
    logic        m_valid, m_fault, m_halt;

    always #5 clk = ~clk;

    // Out-of-range reads return a marker so any aliasing fetch is visible.
    assign imem_instr = (imem_addr < LIM) ? rom[imem_addr[11:2]] : 32'hBAD0_BAD0;

    ifetch #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the spec rules, compare after the edge.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic free;
        rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        @(posedge clk);
        free = !m_valid || rdy;
        if (r) begin
            m_pc = 32'h0; m_valid = 0; m_instr = 0; m_opc = 0; m_fault = 0; m_halt = 0;
        end else if (!m_halt) begin
            if (rv && (rpc[1:0] != 0 || rpc >= LIM)) begin
                m_fault = 1; m_halt = 1; m_valid = 0;
            end else if (rv) begin
                m_pc = rpc; m_valid = 0;
            end else if (free && m_pc >= LIM) begin
                m_fault = 1; m_halt = 1; m_valid = 0;
            end else if (free) begin
                m_instr = rom[m_pc / 4]; m_opc = m_pc; m_valid = 1; m_pc = m_pc + 4;
            end
        end
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("fault", 32'(fault), 32'(m_fault));
        if (m_valid) begin
            chk("out_pc", out_pc, m_opc);
            chk("out_instr", out_instr, m_instr);
            // Independent property: delivered word always belongs to its PC.
            chk("instr_matches_rom", out_instr, rom[out_pc[11:2]]);
        end
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
    endtask

    logic [31:0] prog [0:5];

    initial begin
        prog[0] = 32'h20020005; prog[1] = 32'h20030003; prog[2] = 32'h00430820;
        prog[3] = 32'h00432022; prog[4] = 32'h00432824; prog[5] = 32'h00433025;
        for (int i = 0; i < WORDS; i++) rom[i] = (i < 6) ? prog[i] : $urandom;
        rst = 1; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        m_pc = 0; m_valid = 0; m_instr = 0; m_opc = 0; m_fault = 0; m_halt = 0;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_fault", 32'(fault), 0);

        // Streaming sample program
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 0, 1);
            chk("seq_instr", out_instr, prog[k]);
            chk("seq_pc", out_pc, 32'(4 * k));
            chk("seq_valid", 32'(out_valid), 1);
        end

        // Stall at out_pc=4
        do_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0);
            chk("stall_instr", out_instr, 32'h20030003);
            chk("stall_pc", out_pc, 32'h4);
            chk("stall_addr", imem_addr, 32'h8);
        end
        cycle(0, 0, 0, 1);
        chk("unstall_instr", out_instr, 32'h00430820);
        chk("unstall_pc", out_pc, 32'h8);

        // Redirect to 0x10: one bubble
        do_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h10, 1);
        chk("redir_bubble", 32'(out_valid), 0);
        cycle(0, 0, 0, 1);
        chk("redir_instr", out_instr, 32'h00432824);
        chk("redir_pc", out_pc, 32'h10);

        // Misaligned redirect halts; later legal redirect ignored
        cycle(0, 1, 32'h6, 1);
        chk("mis_fault", 32'(fault), 1);
        chk("mis_valid", 32'(out_valid), 0);
        cycle(0, 1, 32'h0, 1);
        cycle(0, 0, 0, 1);
        chk("halt_fault", 32'(fault), 1);
        chk("halt_valid", 32'(out_valid), 0);
        do_reset();
        chk("clr_fault", 32'(fault), 0);
        cycle(0, 0, 0, 1);
        chk("restart_pc", out_pc, 32'h0);
        chk("restart_instr", out_instr, prog[0]);

        // Run-off past the ROM end
        cycle(0, 1, 32'hFFC, 1);
        cycle(0, 0, 0, 1);
        chk("last_pc", out_pc, 32'hFFC);
        chk("last_instr", out_instr, rom[WORDS-1]);
        cycle(0, 0, 0, 1);
        chk("runoff_fault", 32'(fault), 1);
        chk("runoff_valid", 32'(out_valid), 0);
        cycle(0, 0, 0, 1);
        chk("runoff_hold", 32'(out_valid), 0);

        // Reset during a stall
        do_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("rststall_valid", 32'(out_valid), 0);
        chk("rststall_addr", imem_addr, 0);
        chk("rststall_fault", 32'(fault), 0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic        r, rv, rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) < 3);
            rv  = ($urandom_range(0, 99) < 12);
            rdy = ($urandom_range(0, 99) < 70);
            case ($urandom_range(0, 9))
                0:       rpc = $urandom;                                   // mostly illegal
                1:       rpc = 32'(4 * $urandom_range(WORDS - 4, WORDS - 1)); // near the end
                default: rpc = 32'(4 * $urandom_range(0, WORDS - 1));
            endcase
            if (m_halt && $urandom_range(0, 3) == 0) r = 1;
            cycle(r, rv, rpc, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
